// File: rtl/dct_req_arbiter.sv
// dct_req_arbiter: shares one in-order 2D-DCT engine between NUM_REQ
// requesters, one 4x4 block (one beat) per transaction.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_valid/s_ready     per-requester block handshake (s_ready one-hot or zero)
//   s_data              requester blocks, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   e_in_valid/ready    registered block stage towards the engine
//   e_in_data           block to engine
//   e_out_valid/ready   engine result handshake
//   e_out_data          engine result
//   m_valid/m_ready     per-requester result handshake
//   m_data              result data, broadcast to all requesters
//   outstanding         blocks accepted but not yet returned
//   err_unexpected      sticky: engine result seen with no tag pending
module dct_req_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned IN_WIDTH        = 128,
   parameter int unsigned OUT_WIDTH       = 192,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  s_valid,
   output logic [NUM_REQ-1:0]                  s_ready,
   input  logic [NUM_REQ*IN_WIDTH-1:0]         s_data,
   output logic                                e_in_valid,
   input  logic                                e_in_ready,
   output logic [IN_WIDTH-1:0]                 e_in_data,
   input  logic                                e_out_valid,
   output logic                                e_out_ready,
   input  logic [OUT_WIDTH-1:0]                e_out_data,
   output logic [NUM_REQ-1:0]                  m_valid,
   input  logic [NUM_REQ-1:0]                  m_ready,
   output logic [OUT_WIDTH-1:0]                m_data,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
   output logic                                err_unexpected
);

   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned IDX_W = ID_W + 1;
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     rr_next;
   logic [ID_W-1:0]     tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [ID_W-1:0]     head;
   logic                empty;
   logic                full;
   logic                slot_free;
   logic                can_issue;
   logic                grant_vld;
   logic [ID_W-1:0]     grant_id;
   logic [IDX_W-1:0]    scan_idx;
   logic [IN_WIDTH-1:0] grant_data;
   logic                pop;

   // FIFO occupancy is tracked by the outstanding counter alone
   assign empty     = (outstanding == '0);
   assign full      = (outstanding == CNT_W'(MAX_OUTSTANDING));
   assign slot_free = e_in_ready | ~e_in_valid;
   assign can_issue = slot_free & ~full & ~reset;

   // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ
   always_comb begin
      s_ready   = '0;
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = '0;
      if (can_issue) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + IDX_W'(k);
            if (scan_idx >= IDX_W'(NUM_REQ)) begin
               scan_idx = scan_idx - IDX_W'(NUM_REQ);
            end
            if (!grant_vld && s_valid[scan_idx[ID_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_id  = scan_idx[ID_W-1:0];
            end
         end
      end
      if (grant_vld) begin
         s_ready[grant_id] = 1'b1;
      end
   end

   // Block selected for the engine stage
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            grant_data = s_data[i*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // Return path: results go to whoever owns the FIFO head
   assign head        = tag_mem[rd_ptr];
   assign e_out_ready = ~empty & m_ready[head];
   assign m_data      = e_out_data;
   assign pop         = e_out_valid & e_out_ready;

   always_comb begin
      m_valid = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         m_valid[j] = e_out_valid & ~empty & (head == ID_W'(j));
      end
   end

   // Engine input stage, arbitration pointer and tag FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         e_in_valid <= 1'b0;
         e_in_data  <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (grant_vld) begin
            e_in_valid <= 1'b1;
            e_in_data  <= grant_data;
            rr_ptr     <= rr_next;
            wr_ptr     <= wr_ptr + PTR_W'(1);
         end else if (slot_free) begin
            e_in_valid <= 1'b0;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Tag storage needs no reset: validity comes from the counter
   always_ff @(posedge clk) begin
      if (!reset && grant_vld) begin
         tag_mem[wr_ptr] <= grant_id;
      end
   end

   // In-flight counter and sticky protocol error
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding    <= '0;
         err_unexpected <= 1'b0;
      end else begin
         unique case ({grant_vld, pop})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (e_out_valid && empty) begin
            err_unexpected <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dct_req_arbiter.sv
module tb_dct_req_arbiter;

   localparam int N    = 4;
   localparam int IW   = 128;
   localparam int OW   = 192;
   localparam int MAXO = 8;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready;
   logic [N*IW-1:0] s_data;
   logic            e_in_valid;
   logic            e_in_ready;
   logic [IW-1:0]   e_in_data;
   logic            e_out_valid;
   logic            e_out_ready;
   logic [OW-1:0]   e_out_data;
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_ready;
   logic [OW-1:0]   m_data;
   logic [CW-1:0]   outstanding;
   logic            err_unexpected;

   dct_req_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .e_in_valid(e_in_valid), .e_in_ready(e_in_ready), .e_in_data(e_in_data),
      .e_out_valid(e_out_valid), .e_out_ready(e_out_ready), .e_out_data(e_out_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .outstanding(outstanding), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: spec-level state
   int            m_rr = 0;
   bit            m_ein_v = 1'b0;
   logic [IW-1:0] m_ein_d = '0;
   int            tagq[$];
   bit            m_err = 1'b0;
   logic [IW-1:0] engq[$];
   bit            e2e = 1'b0;
   int            last_grant;
   int            last_pop;
   int            gcount;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check combinational outputs, step model, check registered outputs
   task automatic tick();
      int            g;
      bit            sf, can, pop, err_ev, ein_hs;
      logic [N-1:0]  exp_sr, exp_mv;
      bit            exp_eor;
      logic [IW-1:0] blk, ein_d_pre;
      int            popped, id;
      #1;
      sf  = e_in_ready || !m_ein_v;
      can = sf && (tagq.size() < MAXO) && !reset;
      g   = -1;
      if (can) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (g < 0 && s_valid[i]) g = i;
         end
      end
      exp_sr = '0;
      if (g >= 0) exp_sr[g] = 1'b1;
      exp_mv  = '0;
      exp_eor = 1'b0;
      if (tagq.size() > 0) begin
         exp_eor = m_ready[tagq[0]];
         if (e_out_valid) exp_mv[tagq[0]] = 1'b1;
      end
      chk("s_ready", 256'(s_ready), 256'(exp_sr));
      chk("m_valid", 256'(m_valid), 256'(exp_mv));
      chk("e_out_ready", 256'(e_out_ready), 256'(exp_eor));
      chk("m_data", 256'(m_data), 256'(e_out_data));
      pop    = e_out_valid && exp_eor;
      err_ev = e_out_valid && (tagq.size() == 0);
      popped = pop ? tagq[0] : -1;
      if (pop && e2e) begin
         id = int'(e_out_data[IW-1 -: 8]);
         chk("e2e_route", 256'(m_valid), 256'(1) << id);
      end
      blk       = (g >= 0) ? s_data[g*IW +: IW] : '0;
      ein_hs    = m_ein_v && e_in_ready;
      ein_d_pre = m_ein_d;
      @(posedge clk);
      #1;
      last_grant = g;
      last_pop   = popped;
      if (g >= 0) gcount++;
      if (reset) begin
         m_rr = 0; m_ein_v = 1'b0; m_ein_d = '0; m_err = 1'b0;
         tagq.delete(); engq.delete();
      end else begin
         if (pop) tagq.pop_front();
         if (g >= 0) begin
            m_ein_v = 1'b1;
            m_ein_d = blk;
            tagq.push_back(g);
            m_rr = (g + 1) % N;
         end else if (sf) begin
            m_ein_v = 1'b0;
         end
         if (err_ev) m_err = 1'b1;
         if (ein_hs) engq.push_back(ein_d_pre);
         if (pop && engq.size() > 0) engq.pop_front();
      end
      chk("e_in_valid", 256'(e_in_valid), 256'(m_ein_v));
      chk("e_in_data", 256'(e_in_data), 256'(m_ein_d));
      chk("outstanding", 256'(outstanding), 256'(tagq.size()));
      chk("err_unexpected", 256'(err_unexpected), 256'(m_err));
   endtask

   task automatic idle_inputs();
      s_valid = '0; e_in_ready = 1'b0; e_out_valid = 1'b0; m_ready = '0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic rand_blocks();
      for (int i = 0; i < N; i++) begin
         logic [127:0] r;
         r = {$urandom, $urandom, $urandom, $urandom};
         s_data[i*IW +: IW] = {8'(i), r[119:0]};
      end
   endtask

   initial begin
      logic [OW-1:0] ra, rb, rc;
      reset = 1'b1;
      idle_inputs();
      s_data = '0;
      e_out_data = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, with all requesters asking
      s_valid = '1;
      tick();
      chk("rst_s_ready", 256'(s_ready), 256'(0));
      chk("rst_e_in_valid", 256'(e_in_valid), 256'(0));
      chk("rst_outstanding", 256'(outstanding), 256'(0));
      chk("rst_err", 256'(err_unexpected), 256'(0));
      reset = 1'b0;

      // 1: all valid, engine ready -> 0,1,2,3,0,1
      rand_blocks();
      e_in_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t1_grant", 256'(last_grant), 256'(i % N));
         chk("t1_data", 256'(e_in_data), 256'(s_data[(i % N)*IW +: IW]));
         rand_blocks();
      end

      // 2: only requester 2, then 0 and 3
      reset_dut();
      e_in_ready = 1'b1;
      s_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         rand_blocks();
         tick();
         chk("t2_grant2", 256'(last_grant), 256'(2));
      end
      s_valid = 4'b1001;
      tick();
      chk("t2_grant3", 256'(last_grant), 256'(3));
      tick();
      chk("t2_grant0", 256'(last_grant), 256'(0));

      // 3: engine stall holds the stage
      reset_dut();
      e_in_ready = 1'b1;
      s_valid = 4'b0010;
      rand_blocks();
      tick();
      e_in_ready = 1'b0;
      rand_blocks();
      tick();
      chk("t3_stall_nogrant", 256'(last_grant), 256'(-1));
      e_in_ready = 1'b1;
      tick();
      chk("t3_release_grant", 256'(last_grant), 256'(1));
      chk("t3_new_block", 256'(e_in_data), 256'(s_data[1*IW +: IW]));

      // 4: no returns -> stop at MAX_OUTSTANDING, then one pop frees a slot
      reset_dut();
      e_in_ready = 1'b1;
      s_valid = '1;
      gcount = 0;
      repeat (10) tick();
      chk("t4_grants", 256'(gcount), 256'(MAXO));
      chk("t4_full", 256'(outstanding), 256'(MAXO));
      e_out_valid = 1'b1;
      m_ready = '1;
      e_out_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      chk("t4_no_bypass", 256'(last_grant), 256'(-1));
      chk("t4_pop_tag", 256'(last_pop), 256'(0));
      chk("t4_after_pop", 256'(outstanding), 256'(MAXO - 1));
      e_out_valid = 1'b0;
      tick();
      chk("t4_regrant", 256'(last_grant), 256'(0));

      // 5: in-order routing and head-of-line backpressure
      reset_dut();
      e_in_ready = 1'b1;
      s_valid = 4'b0010; tick();
      s_valid = 4'b1000; tick();
      s_valid = 4'b0001; tick();
      s_valid = '0;
      ra = {6{32'hA0A0_0001}};
      rb = {6{32'hB0B0_0002}};
      rc = {6{32'hC0C0_0003}};
      m_ready = 4'b0111;
      e_out_valid = 1'b1;
      e_out_data = ra;
      tick();
      chk("t5_pop_a", 256'(last_pop), 256'(1));
      e_out_data = rb;
      #1;
      chk("t5_stall_ready", 256'(e_out_ready), 256'(0));
      chk("t5_stall_mvalid", 256'(m_valid), 256'(4'b1000));
      tick();
      chk("t5_stall_nopop", 256'(last_pop), 256'(-1));
      tick();
      m_ready = '1;
      tick();
      chk("t5_pop_b", 256'(last_pop), 256'(3));
      e_out_data = rc;
      tick();
      chk("t5_pop_c", 256'(last_pop), 256'(0));
      e_out_valid = 1'b0;
      tick();
      chk("t5_empty", 256'(outstanding), 256'(0));

      // 6: unexpected result, then reset with blocks in flight
      e_out_valid = 1'b1;
      #1;
      chk("t6_eor", 256'(e_out_ready), 256'(0));
      chk("t6_mvalid", 256'(m_valid), 256'(0));
      tick();
      chk("t6_err_set", 256'(err_unexpected), 256'(1));
      e_out_valid = 1'b0;
      tick();
      chk("t6_err_sticky", 256'(err_unexpected), 256'(1));
      s_valid = '1;
      e_in_ready = 1'b1;
      repeat (5) tick();
      chk("t6_five_out", 256'(outstanding), 256'(5));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_out", 256'(outstanding), 256'(0));
      chk("t6_rst_ein", 256'(e_in_valid), 256'(0));
      chk("t6_rst_err", 256'(err_unexpected), 256'(0));
      s_valid = 4'b1001;
      tick();
      chk("t6_rr_reset", 256'(last_grant), 256'(0));

      // Random traffic through a modelled in-order engine
      reset_dut();
      e2e = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rand_blocks();
         s_valid    = N'($urandom);
         e_in_ready = ($urandom % 4) != 0;
         m_ready    = ((c / 50) % 4 == 3) ? '0 : N'($urandom | $urandom);
         e_out_valid = (engq.size() > 0) && (($urandom % 3) != 0);
         if (e_out_valid) e_out_data = {64'(c), engq[0]};
         else             e_out_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
